// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: uop encodings, flag types and the shared ALU evaluation
// used by the ALU arbiter. Configuration macro for the block: ALU_ARB_RR_EN.
package alu_arbiter_pkg;

    localparam int UOP_W = 5;

    localparam logic [UOP_W-1:0] UOP_ADD = 5'h00;
    localparam logic [UOP_W-1:0] UOP_SUB = 5'h01;
    localparam logic [UOP_W-1:0] UOP_AND = 5'h02;
    localparam logic [UOP_W-1:0] UOP_EOR = 5'h03;
    localparam logic [UOP_W-1:0] UOP_CMP = 5'h04;
    localparam logic [UOP_W-1:0] UOP_LSL = 5'h05;
    localparam logic [UOP_W-1:0] UOP_LSR = 5'h06;
    localparam logic [UOP_W-1:0] UOP_MOV = 5'h07;
    localparam logic [UOP_W-1:0] UOP_STR = 5'h08;
    localparam logic [UOP_W-1:0] UOP_LDR = 5'h09;

    // Architectural flags, index 0 is Z so a literal 4'bZCNV reads naturally
    typedef logic [0:3] flags_t;

    localparam int FLAGS_Z = 0;
    localparam int FLAGS_C = 1;
    localparam int FLAGS_N = 2;
    localparam int FLAGS_V = 3;

    typedef struct packed {
        logic [31:0] result;
        flags_t      flags;
    } alu_out_t;

    // Only the arithmetic and shift-left uops are allowed to update flags
    function automatic logic uop_sets_flags(input logic [UOP_W-1:0] uop);
        return (uop == UOP_ADD) || (uop == UOP_SUB) ||
               (uop == UOP_CMP) || (uop == UOP_LSL);
    endfunction

    // Everything outside the ten known encodings is answered with an error
    function automatic logic uop_valid(input logic [UOP_W-1:0] uop);
        return uop <= UOP_LDR;
    endfunction

    // Shared combinational ALU; C is carry for ADD, borrow for SUB/CMP,
    // and the last bit shifted out for LSL. STR/LDR form base+offset.
    function automatic alu_out_t alu_eval(input logic [UOP_W-1:0] uop,
                                          input logic [31:0] lhs,
                                          input logic [31:0] rhs);
        alu_out_t res;
        logic [32:0] wide;
        res  = '0;
        wide = '0;
        case (uop)
            UOP_ADD, UOP_STR, UOP_LDR: begin
                wide = {1'b0, lhs} + {1'b0, rhs};
                res.flags[FLAGS_C] = wide[32];
                res.flags[FLAGS_V] = (lhs[31] == rhs[31]) && (wide[31] != lhs[31]);
            end
            UOP_SUB, UOP_CMP: begin
                wide = {1'b0, lhs} - {1'b0, rhs};
                res.flags[FLAGS_C] = wide[32];
                res.flags[FLAGS_V] = (lhs[31] != rhs[31]) && (wide[31] != lhs[31]);
            end
            UOP_AND: wide = {1'b0, lhs & rhs};
            UOP_EOR: wide = {1'b0, lhs ^ rhs};
            UOP_LSL: begin
                wide = {1'b0, lhs} << rhs[4:0];
                res.flags[FLAGS_C] = wide[32];
            end
            UOP_LSR: wide = {1'b0, lhs >> rhs[4:0]};
            UOP_MOV: wide = {1'b0, rhs};
            default: wide = '0;
        endcase
        res.result         = wide[31:0];
        res.flags[FLAGS_Z] = (wide[31:0] == 32'd0);
        res.flags[FLAGS_N] = wide[31];
        return res;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request and response channels of both ALU ports.
// master = requester/consumer side, slave = the arbiter.
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    import alu_arbiter_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_lhs;
    logic [31:0]      req0_rhs;
    logic [UOP_W-1:0] req0_uop;
    logic [TAG_W-1:0] req0_tag;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [31:0]      rsp0_result;
    logic [TAG_W-1:0] rsp0_tag;
    logic             rsp0_err;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_lhs;
    logic [31:0]      req1_rhs;
    logic [UOP_W-1:0] req1_uop;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [31:0]      rsp1_result;
    logic [TAG_W-1:0] rsp1_tag;
    logic             rsp1_err;

    modport master (
        output req0_valid, req0_lhs, req0_rhs, req0_uop, req0_tag, rsp0_ready,
        output req1_valid, req1_lhs, req1_rhs, req1_uop, req1_tag, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_tag, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_tag, rsp1_err
    );

    modport slave (
        input  req0_valid, req0_lhs, req0_rhs, req0_uop, req0_tag, rsp0_ready,
        input  req1_valid, req1_lhs, req1_rhs, req1_uop, req1_tag, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_tag, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_tag, rsp1_err
    );

endinterface

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: one-grant-per-cycle arbitration between the two ALU ports.
// ALU_ARB_RR_EN defined: round-robin on conflict; otherwise port 0 has
// priority and port 1 is forced through after STARVE_LIMIT lost conflicts.
module alu_arb_pick
    import alu_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic elig0_i,
    input  logic elig1_i,
    output logic grant0_o,
    output logic grant1_o
);

`ifdef ALU_ARB_RR_EN
    logic rr_q;
    logic rr_d;

    // Conflict goes to the pointer and hands the pointer to the loser
    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        rr_d     = rr_q;
        if (rst_n) begin
            if (elig0_i && elig1_i) begin
                grant0_o = ~rr_q;
                grant1_o = rr_q;
                rr_d     = ~rr_q;
            end else begin
                grant0_o = elig0_i;
                grant1_o = elig1_i;
            end
        end
    end

    // Round-robin pointer, starts at port 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else        rr_q <= rr_d;
    end
`else
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    // Port 0 wins conflicts until port 1 has lost STARVE_LIMIT in a row
    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        starve_d = starve_q;
        if (rst_n) begin
            if (elig0_i && elig1_i) begin
                if (starve_q == CNT_W'(STARVE_LIMIT)) begin
                    grant1_o = 1'b1;
                    starve_d = '0;
                end else begin
                    grant0_o = 1'b1;
                    starve_d = starve_q + 1'b1;
                end
            end else if (elig1_i) begin
                grant1_o = 1'b1;
                starve_d = '0;
            end else if (elig0_i) begin
                grant0_o = 1'b1;
            end
        end
    end

    // Starvation counter of consecutive port-1 conflict losses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute port (0)
// and the address-generation port (1), with registered back-pressurable
// responses and the architectural flags register. Macro: ALU_ARB_RR_EN.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TAG_W        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_arbiter_if.slave bus,
    output flags_t      flags_q
);

    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic [UOP_W-1:0] aluUop;
    logic [31:0]      aluLhs;
    logic [31:0]      aluRhs;
    alu_out_t         aluOut;
    flags_t           flags_d;

    logic             rsp0Valid_q;
    logic [31:0]      rsp0Result_q;
    logic [TAG_W-1:0] rsp0Tag_q;
    logic             rsp0Err_q;
    logic             rsp1Valid_q;
    logic [31:0]      rsp1Result_q;
    logic [TAG_W-1:0] rsp1Tag_q;
    logic             rsp1Err_q;

    assign elig0 = bus.req0_valid && (!rsp0Valid_q || bus.rsp0_ready);
    assign elig1 = bus.req1_valid && (!rsp1Valid_q || bus.rsp1_ready);

    alu_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) uPick (
        .clk     (clk),
        .rst_n   (rst_n),
        .elig0_i (elig0),
        .elig1_i (elig1),
        .grant0_o(grant0),
        .grant1_o(grant1)
    );

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.rsp0_valid  = rsp0Valid_q;
    assign bus.rsp0_result = rsp0Result_q;
    assign bus.rsp0_tag    = rsp0Tag_q;
    assign bus.rsp0_err    = rsp0Err_q;
    assign bus.rsp1_valid  = rsp1Valid_q;
    assign bus.rsp1_result = rsp1Result_q;
    assign bus.rsp1_tag    = rsp1Tag_q;
    assign bus.rsp1_err    = rsp1Err_q;

    // Steer the granted port onto the ALU; idle cycles present MOV 0,0
    always_comb begin
        aluUop = UOP_MOV;
        aluLhs = '0;
        aluRhs = '0;
        if (grant0) begin
            aluUop = bus.req0_uop;
            aluLhs = bus.req0_lhs;
            aluRhs = bus.req0_rhs;
        end else if (grant1) begin
            aluUop = bus.req1_uop;
            aluLhs = bus.req1_lhs;
            aluRhs = bus.req1_rhs;
        end
    end

    assign aluOut = alu_eval(aluUop, aluLhs, aluRhs);

    // Flags follow the ALU only for flag-setting uops granted on port 0
    always_comb begin
        flags_d = flags_q;
        if (grant0 && uop_sets_flags(bus.req0_uop)) flags_d = aluOut.flags;
    end

    // Architectural flags register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= flags_d;
    end

    // Port 0 response slot: capture on grant, drain on ready, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0Valid_q  <= 1'b0;
            rsp0Result_q <= '0;
            rsp0Tag_q    <= '0;
            rsp0Err_q    <= 1'b0;
        end else if (grant0) begin
            rsp0Valid_q  <= 1'b1;
            rsp0Result_q <= uop_valid(bus.req0_uop) ? aluOut.result : 32'd0;
            rsp0Tag_q    <= bus.req0_tag;
            rsp0Err_q    <= !uop_valid(bus.req0_uop);
        end else if (bus.rsp0_ready) begin
            rsp0Valid_q  <= 1'b0;
        end
    end

    // Port 1 response slot: capture on grant, drain on ready, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1Valid_q  <= 1'b0;
            rsp1Result_q <= '0;
            rsp1Tag_q    <= '0;
            rsp1Err_q    <= 1'b0;
        end else if (grant1) begin
            rsp1Valid_q  <= 1'b1;
            rsp1Result_q <= uop_valid(bus.req1_uop) ? aluOut.result : 32'd0;
            rsp1Tag_q    <= bus.req1_tag;
            rsp1Err_q    <= !uop_valid(bus.req1_uop);
        end else if (bus.rsp1_ready) begin
            rsp1Valid_q  <= 1'b0;
        end
    end

endmodule
